// File: rtl/cc_level_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cc_level_sequencer_pkg
//  Description : Shared state encoding for the level sequencer. The numeric
//                codes are visible on the debug state output, so they are
//                fixed here once.
//  Revision    : 1.0  initial release
// ============================================================================
package cc_level_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_PLAYING  = 3'd1,
    ST_ADVANCE  = 3'd2,
    ST_WIN      = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_e;

  // A restart is honoured from every state that is waiting for the player.
  function automatic logic accepts_start(input state_e s);
    return (s == ST_IDLE) || (s == ST_WIN) || (s == ST_GAMEOVER);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cc_level_sequencer_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : cc_level_sequencer_edge_detect
//  Description : Rising-edge detector. One history flop plus AND-NOT; the
//                event is combinational so the consumer can act on the same
//                clock edge that samples the input.
//  Revision    : 1.0  initial release
// ============================================================================
module cc_level_sequencer_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic event_o
);

  logic seen_q;

  // History of the input, cleared by reset so a level held through reset fires once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seen_q <= 1'b0;
    end else begin
      seen_q <= sig_i;
    end
  end

  assign event_o = sig_i & ~seen_q;

endmodule
`default_nettype wire

// File: rtl/cc_level_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cc_level_sequencer
//  Description : Owns the game level. Advances on a goal edge, clears the
//                board for a fixed hold time between levels, ends the game on
//                a crash edge and latches the win at the final level.
//  Revision    : 1.0  initial release
// ============================================================================
module cc_level_sequencer
  import cc_level_sequencer_pkg::*;
#(
  parameter int COUNTER_LEVELS_DATAWIDTH = 5,
  parameter int MAX_LEVEL                = 5,
  parameter int HOLD_CYCLES              = 16
) (
  input  logic                                CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                                CC_LEVEL_SEQUENCER_RESET_InHigh,
  input  logic                                CC_LEVEL_SEQUENCER_start_InLow,
  input  logic                                CC_LEVEL_SEQUENCER_goal_InHigh,
  input  logic                                CC_LEVEL_SEQUENCER_crash_InHigh,
  output logic [COUNTER_LEVELS_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_level_Out,
  output logic                                CC_LEVEL_SEQUENCER_levelup_OutHigh,
  output logic                                CC_LEVEL_SEQUENCER_boardclear_OutHigh,
  output logic                                CC_LEVEL_SEQUENCER_win_OutHigh,
  output logic [STATE_W-1:0]                  CC_LEVEL_SEQUENCER_state_Out
);

  localparam int LW     = COUNTER_LEVELS_DATAWIDTH;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [LW-1:0]     LEVEL_MAX  = LW'(MAX_LEVEL);
  localparam logic [LW-1:0]     LEVEL_LAST = LW'(MAX_LEVEL - 1);
  localparam logic [LW-1:0]     LEVEL_ONE  = LW'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

  wire clk = CC_LEVEL_SEQUENCER_CLOCK_50;
  wire rst = CC_LEVEL_SEQUENCER_RESET_InHigh;

  logic w_start_ev;
  logic w_goal_ev;
  logic w_crash_ev;

  state_e          state_q,      state_d;
  logic [LW-1:0]   level_q,      level_d;
  logic [HOLD_W-1:0] hold_q,     hold_d;
  logic            levelup_q,    levelup_d;
  logic            boardclear_q;
  logic            win_q;

  cc_level_sequencer_edge_detect u_start_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .sig_i   (~CC_LEVEL_SEQUENCER_start_InLow),
    .event_o (w_start_ev)
  );

  cc_level_sequencer_edge_detect u_goal_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .sig_i   (CC_LEVEL_SEQUENCER_goal_InHigh),
    .event_o (w_goal_ev)
  );

  cc_level_sequencer_edge_detect u_crash_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .sig_i   (CC_LEVEL_SEQUENCER_crash_InHigh),
    .event_o (w_crash_ev)
  );

  // Next state, next level, hold countdown and the level-up pulse.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    hold_d    = hold_q;
    levelup_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_WIN, ST_GAMEOVER: begin
        if (w_start_ev && accepts_start(state_q)) begin
          state_d = ST_PLAYING;
          level_d = '0;
        end
      end
      ST_PLAYING: begin
        // Crash wins a tie with goal: the player does not get credit for the level.
        if (w_crash_ev) begin
          state_d = ST_GAMEOVER;
        end else if (w_goal_ev) begin
          levelup_d = 1'b1;
          if (level_q == LEVEL_LAST) begin
            level_d = LEVEL_MAX;
            state_d = ST_WIN;
          end else begin
            level_d = level_q + LEVEL_ONE;
            state_d = ST_ADVANCE;
            hold_d  = '0;
          end
        end
      end
      ST_ADVANCE: begin
        // All events are dropped here; edge history keeps tracking so nothing is queued.
        if (hold_q == HOLD_LAST) begin
          state_d = ST_PLAYING;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State, level and output flags; flags follow the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      hold_q       <= '0;
      levelup_q    <= 1'b0;
      boardclear_q <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      hold_q       <= hold_d;
      levelup_q    <= levelup_d;
      boardclear_q <= (state_d == ST_ADVANCE);
      win_q        <= (state_d == ST_WIN);
    end
  end

  assign CC_LEVEL_SEQUENCER_level_Out          = level_q;
  assign CC_LEVEL_SEQUENCER_levelup_OutHigh    = levelup_q;
  assign CC_LEVEL_SEQUENCER_boardclear_OutHigh = boardclear_q;
  assign CC_LEVEL_SEQUENCER_win_OutHigh        = win_q;
  assign CC_LEVEL_SEQUENCER_state_Out          = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cc_level_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cc_level_sequencer
//  Description : Directed bench for the level sequencer with a behavioural
//                game model checked every cycle plus literal spot checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cc_level_sequencer;

  localparam int W    = 5;
  localparam int MAXL = 5;
  localparam int HOLD = 16;

  localparam int M_IDLE = 0, M_PLAY = 1, M_ADV = 2, M_WIN = 3, M_OVER = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_n = 1'b1;
  logic         goal = 1'b0;
  logic         crash = 1'b0;
  logic [W-1:0] level;
  logic         levelup;
  logic         bc;
  logic         win;
  logic [2:0]   state;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Game model: what the player should see, stated in terms of the rules.
  int m_mode = M_IDLE;
  int m_level = 0;
  int m_left = 0;
  bit m_levelup = 0;
  bit m_start_prev = 0, m_goal_prev = 0, m_crash_prev = 0;

  cc_level_sequencer #(
    .COUNTER_LEVELS_DATAWIDTH (W),
    .MAX_LEVEL                (MAXL),
    .HOLD_CYCLES              (HOLD)
  ) dut (
    .CC_LEVEL_SEQUENCER_CLOCK_50           (clk),
    .CC_LEVEL_SEQUENCER_RESET_InHigh       (rst),
    .CC_LEVEL_SEQUENCER_start_InLow        (start_n),
    .CC_LEVEL_SEQUENCER_goal_InHigh        (goal),
    .CC_LEVEL_SEQUENCER_crash_InHigh       (crash),
    .CC_LEVEL_SEQUENCER_level_Out          (level),
    .CC_LEVEL_SEQUENCER_levelup_OutHigh    (levelup),
    .CC_LEVEL_SEQUENCER_boardclear_OutHigh (bc),
    .CC_LEVEL_SEQUENCER_win_OutHigh        (win),
    .CC_LEVEL_SEQUENCER_state_Out          (state)
  );

  always #5 clk = ~clk;

  // Model update on every rising edge, from the inputs held stable since the last falling edge.
  always @(posedge clk) begin
    bit s_ev, g_ev, c_ev;
    s_ev = !start_n && !m_start_prev;
    g_ev = goal && !m_goal_prev;
    c_ev = crash && !m_crash_prev;
    m_start_prev = !start_n;
    m_goal_prev  = goal;
    m_crash_prev = crash;
    m_levelup    = 0;
    if (rst) begin
      m_mode = M_IDLE; m_level = 0; m_left = 0;
      m_start_prev = 0; m_goal_prev = 0; m_crash_prev = 0;
    end else if (m_mode == M_PLAY) begin
      if (c_ev) m_mode = M_OVER;
      else if (g_ev) begin
        m_level = m_level + 1;
        m_levelup = 1;
        if (m_level == MAXL) m_mode = M_WIN;
        else begin m_mode = M_ADV; m_left = HOLD; end
      end
    end else if (m_mode == M_ADV) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = M_PLAY;
    end else if (s_ev) begin
      m_mode = M_PLAY; m_level = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",      int'(state),   m_mode);
      chk("level",      int'(level),   m_level);
      chk("levelup",    int'(levelup), int'(m_levelup));
      chk("boardclear", int'(bc),      int'(m_mode == M_ADV));
      chk("win",        int'(win),     int'(m_mode == M_WIN));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start_n = 1'b1; goal = 1'b0; crash = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic start_pulse();
    start_n = 1'b0; cyc(1); start_n = 1'b1; cyc(1);
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (bc === 1'b1 && n < 40) begin cyc(1); n++; end
    n_cmp++;
    if (n >= 40) begin
      n_bad++;
      $display("FAIL %s_timeout: boardclear still %0d after %0d cycles, expected 0", tag, bc, n);
    end
  endtask

  task automatic goal_pulse(input string tag);
    goal = 1'b1; cyc(1); goal = 1'b0;
    wait_clear(tag);
  endtask

  initial begin
    int lu_cnt, bc_cnt;
    do_reset();
    chk_en = 1;
    chk("rst_state", int'(state), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_bc",    int'(bc),    0);

    // Start from IDLE.
    start_n = 1'b0; cyc(1);
    chk("start_state",   int'(state),   1);
    chk("start_level",   int'(level),   0);
    chk("start_levelup", int'(levelup), 0);
    start_n = 1'b1;

    // Goal held 40 cycles: one increment, one pulse, 16 cycles of board clear.
    goal = 1'b1; lu_cnt = 0; bc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (levelup) lu_cnt++;
      if (bc) bc_cnt++;
    end
    chk("hold_levelups", lu_cnt, 1);
    chk("hold_bc_cycles", bc_cnt, 16);
    chk("hold_level", int'(level), 1);
    chk("hold_state", int'(state), 1);
    goal = 1'b0; cyc(1);

    // Five goals from a fresh game reach WIN; further goals are ignored.
    do_reset(); start_pulse();
    for (int i = 1; i <= 5; i++) begin
      goal_pulse("climb");
      chk("climb_level", int'(level), i);
    end
    chk("win_state", int'(state), 3);
    chk("win_flag",  int'(win),   1);
    goal_pulse("after_win"); goal_pulse("after_win");
    chk("win_level_stuck", int'(level), 5);

    // Restart from WIN, reach level 2, then goal and crash together.
    start_pulse();
    chk("restart_level", int'(level), 0);
    goal_pulse("to2"); goal_pulse("to2");
    goal = 1'b1; crash = 1'b1; cyc(1);
    chk("tie_state",   int'(state),   4);
    chk("tie_level",   int'(level),   2);
    chk("tie_levelup", int'(levelup), 0);
    goal = 1'b0; crash = 1'b0; cyc(1);
    start_pulse();
    chk("over_restart_state", int'(state), 1);
    chk("over_restart_level", int'(level), 0);

    // Reset in the seventh ADVANCE cycle at level 3.
    goal_pulse("to3"); goal_pulse("to3");
    goal = 1'b1; cyc(1); goal = 1'b0;
    cyc(6);
    chk("adv7_bc",    int'(bc),    1);
    chk("adv7_level", int'(level), 3);
    rst = 1'b1; cyc(1);
    chk("midrst_state", int'(state), 0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_bc",    int'(bc),    0);
    rst = 1'b0; cyc(1);

    // Events inside ADVANCE are dropped and do not shorten or extend it.
    start_pulse();
    goal = 1'b1; cyc(1); goal = 1'b0;
    cyc(2);
    goal = 1'b1; crash = 1'b1; start_n = 1'b0; cyc(1);
    goal = 1'b0; crash = 1'b0; start_n = 1'b1;
    bc_cnt = 4;
    for (int i = 0; i < 40 && bc === 1'b1; i++) begin
      cyc(1);
      if (bc) bc_cnt++;
    end
    chk("ign_bc_cycles", bc_cnt, 16);
    chk("ign_state", int'(state), 1);
    chk("ign_level", int'(level), 1);
    cyc(3);
    chk("ign_noqueue_state", int'(state), 1);
    chk("ign_noqueue_level", int'(level), 1);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
